// File: rtl/saper_board_pkg.sv
// Shared board constants and enums for the saper board pipeline.
package saper_board_pkg;

  localparam int unsigned EASY_DIM = 8;
  localparam int unsigned MED_DIM  = 10;
  localparam int unsigned HARD_DIM = 16;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_EASY = 2'd1,
    LVL_MED  = 2'd2,
    LVL_HARD = 2'd3
  } level_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/num_draw_sequencer_if.sv
// Draw-request handshake between the number sequencer and the digit renderer.
interface num_draw_sequencer_if;

  logic        draw_req;
  logic        draw_ack;
  logic [4:0]  draw_field_x;
  logic [4:0]  draw_field_y;
  logic [2:0]  draw_digit;
  logic [10:0] draw_xpos;
  logic [10:0] draw_ypos;

  modport master (
    output draw_req, draw_field_x, draw_field_y, draw_digit, draw_xpos, draw_ypos,
    input  draw_ack
  );

  modport slave (
    input  draw_req, draw_field_x, draw_field_y, draw_digit, draw_xpos, draw_ypos,
    output draw_ack
  );

endinterface

// File: rtl/num_field_select.sv
// Picks one field's defuse bit and count out of the array set for a level.
module num_field_select
  import saper_board_pkg::*;
(
  input  level_e                  lvl,
  input  logic [3:0]              col,
  input  logic [3:0]              row,
  input  logic [7:0][7:0][2:0]    num_arr_easy,
  input  logic [9:0][9:0][2:0]    num_arr_medium,
  input  logic [15:0][15:0][2:0]  num_arr_hard,
  input  logic [7:0][7:0]         defuse_arr_easy,
  input  logic [9:0][9:0]         defuse_arr_medium,
  input  logic [15:0][15:0]       defuse_arr_hard,
  output logic                    fld_defuse,
  output logic [2:0]              fld_num,
  output logic [4:0]              fld_dim
);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    fld_defuse = 1'b0;
    fld_num    = 3'd0;
    fld_dim    = 5'(EASY_DIM);
    case (lvl)
      LVL_EASY: begin
        fld_defuse = defuse_arr_easy[col[2:0]][row[2:0]];
        fld_num    = num_arr_easy[col[2:0]][row[2:0]];
        fld_dim    = 5'(EASY_DIM);
      end
      LVL_MED: begin
        fld_defuse = defuse_arr_medium[col][row];
        fld_num    = num_arr_medium[col][row];
        fld_dim    = 5'(MED_DIM);
      end
      LVL_HARD: begin
        fld_defuse = defuse_arr_hard[col][row];
        fld_num    = num_arr_hard[col][row];
        fld_dim    = 5'(HARD_DIM);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/num_draw_sequencer.sv
// Per-frame scan of defused fields, issuing one digit draw request per nonzero count.
module num_draw_sequencer
  import saper_board_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              level,
  input  logic                    explode,
  input  logic                    frame_start,
  input  logic [10:0]             board_xpos,
  input  logic [10:0]             board_ypos,
  input  logic [5:0]              field_size,
  input  logic [7:0][7:0][2:0]    num_arr_easy,
  input  logic [9:0][9:0][2:0]    num_arr_medium,
  input  logic [15:0][15:0][2:0]  num_arr_hard,
  input  logic [7:0][7:0]         defuse_arr_easy,
  input  logic [9:0][9:0]         defuse_arr_medium,
  input  logic [15:0][15:0]       defuse_arr_hard,
  num_draw_sequencer_if.master    dbus,
  output logic                    scan_busy,
  output logic                    scan_done
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_SCAN = S_SCAN;
  localparam logic [1:0] ST_REQ  = S_REQ;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]  state_q, state_d;
  level_e      lvl_q, lvl_d;
  logic [3:0]  col_q, col_d, row_q, row_d;
  logic [10:0] xacc_q, xacc_d, yacc_q, yacc_d;
  logic        req_q, req_d;
  logic [4:0]  fx_q, fx_d, fy_q, fy_d;
  logic [2:0]  digit_q, digit_d;
  logic [10:0] dx_q, dx_d, dy_q, dy_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        fld_defuse;
  logic [2:0]  fld_num;
  logic [4:0]  fld_dim;

  num_field_select u_sel (
    .lvl               (lvl_q),
    .col               (col_q),
    .row               (row_q),
    .num_arr_easy      (num_arr_easy),
    .num_arr_medium    (num_arr_medium),
    .num_arr_hard      (num_arr_hard),
    .defuse_arr_easy   (defuse_arr_easy),
    .defuse_arr_medium (defuse_arr_medium),
    .defuse_arr_hard   (defuse_arr_hard),
    .fld_defuse        (fld_defuse),
    .fld_num           (fld_num),
    .fld_dim           (fld_dim)
  );

  logic        last_col, last_field, abort, qualify;
  logic [3:0]  adv_col, adv_row;
  logic [10:0] adv_xacc, adv_yacc;

  // Next scan position; pixel origins track by repeated addition of the pitch.
  always_comb begin
    last_col   = ({1'b0, col_q} == fld_dim - 5'd1);
    last_field = last_col && ({1'b0, row_q} == fld_dim - 5'd1);
    abort      = explode || (level != lvl_q);
    qualify    = fld_defuse && (fld_num != 3'd0);
    if (last_col) begin
      adv_col  = 4'd0;
      adv_xacc = board_xpos;
      adv_row  = row_q + 4'd1;
      adv_yacc = yacc_q + {5'd0, field_size};
    end else begin
      adv_col  = col_q + 4'd1;
      adv_xacc = xacc_q + {5'd0, field_size};
      adv_row  = row_q;
      adv_yacc = yacc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    col_d   = col_q;
    row_d   = row_q;
    xacc_d  = xacc_q;
    yacc_d  = yacc_q;
    req_d   = req_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    digit_d = digit_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start && (level != LVL_NONE) && !explode) begin
          state_d = ST_SCAN;
          lvl_d   = level_e'(level);
          col_d   = 4'd0;
          row_d   = 4'd0;
          xacc_d  = board_xpos;
          yacc_d  = board_ypos;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN, ST_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (state_q == ST_SCAN && qualify) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          fx_d    = {1'b0, col_q};
          fy_d    = {1'b0, row_q};
          digit_d = fld_num;
          dx_d    = xacc_q;
          dy_d    = yacc_q;
        end else if (state_q == ST_SCAN || dbus.draw_ack) begin
          req_d = 1'b0;
          if (last_field) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SCAN;
            col_d   = adv_col;
            row_d   = adv_row;
            xacc_d  = adv_xacc;
            yacc_d  = adv_yacc;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= LVL_NONE;
      col_q   <= '0;
      row_q   <= '0;
      xacc_q  <= '0;
      yacc_q  <= '0;
      req_q   <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      digit_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xacc_q  <= xacc_d;
      yacc_q  <= yacc_d;
      req_q   <= req_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      digit_q <= digit_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dbus.draw_req     = req_q;
  assign dbus.draw_field_x = fx_q;
  assign dbus.draw_field_y = fy_q;
  assign dbus.draw_digit   = digit_q;
  assign dbus.draw_xpos    = dx_q;
  assign dbus.draw_ypos    = dy_q;
  assign scan_busy         = busy_q;
  assign scan_done         = done_q;

endmodule

// File: tb/tb_num_draw_sequencer.sv
// Directed bench for num_draw_sequencer with hand-computed request timing and coordinates.
module tb_num_draw_sequencer;
  import saper_board_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, explode, frame_start;
  logic [1:0]  level;
  logic [10:0] bx, by;
  logic [5:0]  fs;
  logic [7:0][7:0][2:0]   ne;
  logic [9:0][9:0][2:0]   nm;
  logic [15:0][15:0][2:0] nh;
  logic [7:0][7:0]        de;
  logic [9:0][9:0]        dm;
  logic [15:0][15:0]      dh;
  logic scan_busy, scan_done;

  num_draw_sequencer_if dif ();

  num_draw_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .level             (level),
    .explode           (explode),
    .frame_start       (frame_start),
    .board_xpos        (bx),
    .board_ypos        (by),
    .field_size        (fs),
    .num_arr_easy      (ne),
    .num_arr_medium    (nm),
    .num_arr_hard      (nh),
    .defuse_arr_easy   (de),
    .defuse_arr_medium (dm),
    .defuse_arr_hard   (dh),
    .dbus              (dif.master),
    .scan_busy         (scan_busy),
    .scan_done         (scan_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int sample_idx();
    return cyc - t0 + 1;
  endfunction

  // Sample 1 is the cycle right after the start edge.
  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_req(input string tag, input int budget, input int exp_idx);
    while (!dif.draw_req && sample_idx() < budget) step();
    check({tag, "_req_at"}, dif.draw_req ? sample_idx() : -1, exp_idx);
  endtask

  task automatic check_req(input string tag, input int x, input int y, input int d,
                           input int xp, input int yp);
    check({tag, "_req"}, int'(dif.draw_req), 1);
    check({tag, "_x"}, int'(dif.draw_field_x), x);
    check({tag, "_y"}, int'(dif.draw_field_y), y);
    check({tag, "_digit"}, int'(dif.draw_digit), d);
    check({tag, "_xpos"}, int'(dif.draw_xpos), xp);
    check({tag, "_ypos"}, int'(dif.draw_ypos), yp);
  endtask

  task automatic ack_now();
    dif.draw_ack = 1'b1;
    step();
    dif.draw_ack = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n;
    n = 1;
    while (!scan_done && n < 400) begin
      step();
      n++;
    end
    check({tag, "_done_after_ack"}, scan_done ? n : -1, exp_n);
  endtask

  task automatic clear_arrays();
    ne = '0; nm = '0; nh = '0;
    de = '0; dm = '0; dh = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int seen;
    rst = 1'b1; explode = 1'b0; frame_start = 1'b0; level = 2'd0;
    bx = '0; by = '0; fs = '0; dif.draw_ack = 1'b0;
    clear_arrays();
    repeat (3) step();
    check("rst_req", int'(dif.draw_req), 0);
    check("rst_busy", int'(scan_busy), 0);
    check("rst_done", int'(scan_done), 0);
    rst = 1'b0;
    step();

    // Empty easy board: 64 scan cycles then the done cycle.
    level = 2'd1;
    start_frame();
    check("empty_busy_start", int'(scan_busy), 1);
    idx = 1; seen = 0;
    while (!scan_done && idx < 100) begin
      seen |= int'(dif.draw_req);
      step();
      idx++;
    end
    check("empty_done_at", idx, 65);
    check("empty_no_req", seen, 0);
    check("empty_busy_end", int'(scan_busy), 0);
    step();
    check("empty_done_pulse", int'(scan_done), 0);

    // Single easy request at (2,3): index 26 -> visible at sample 28.
    de[2][3] = 1'b1; ne[2][3] = 3'd5;
    bx = 11'd100; by = 11'd40; fs = 6'd50;
    start_frame();
    wait_req("e1", 100, 28);
    check_req("e1", 2, 3, 5, 200, 190);
    ack_now();
    check("e1_req_drop", int'(dif.draw_req), 0);
    wait_done("e1", 38);

    // Same request with ack withheld for 10 cycles.
    step();
    start_frame();
    wait_req("e2", 100, 28);
    for (int k = 0; k < 10; k++) begin
      step();
      check_req("e2_hold", 2, 3, 5, 200, 190);
    end
    ack_now();
    check("e2_req_drop", int'(dif.draw_req), 0);
    wait_done("e2", 38);

    // Hard board, two requests, x accumulator wraps past 2047.
    step();
    clear_arrays();
    level = 2'd3; bx = 11'd2000; by = 11'd10; fs = 6'd63;
    dh[0][1] = 1'b1;   nh[0][1] = 3'd1;
    dh[15][15] = 1'b1; nh[15][15] = 3'd1;
    start_frame();
    wait_req("h1", 100, 18);
    check_req("h1", 0, 1, 1, 2000, 73);
    ack_now();
    wait_req("h2", 400, 258);
    check_req("h2", 15, 15, 1, 897, 955);
    ack_now();
    check("h2_req_drop", int'(dif.draw_req), 0);
    check("h2_done_next", int'(scan_done), 1);
    step();

    // Explode during REQ aborts without scan_done; rescan starts at (0,0).
    clear_arrays();
    level = 2'd1; bx = 11'd100; by = 11'd40; fs = 6'd50;
    de[2][3] = 1'b1; ne[2][3] = 3'd5;
    start_frame();
    wait_req("x1", 100, 28);
    explode = 1'b1;
    step();
    explode = 1'b0;
    check("x1_req_abort", int'(dif.draw_req), 0);
    check("x1_busy_abort", int'(scan_busy), 0);
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      seen |= int'(scan_done) | int'(scan_busy);
      step();
    end
    check("x1_quiet", seen, 0);
    de[0][0] = 1'b1; ne[0][0] = 3'd3;
    start_frame();
    wait_req("x2", 10, 2);
    check_req("x2", 0, 0, 3, 100, 40);
    explode = 1'b1;
    step();
    explode = 1'b0;
    check("x2_busy_abort", int'(scan_busy), 0);

    // Level change mid-scan aborts like explode.
    clear_arrays();
    level = 2'd2;
    start_frame();
    repeat (3) step();
    level = 2'd1;
    step();
    check("lvl_chg_busy", int'(scan_busy), 0);
    check("lvl_chg_req", int'(dif.draw_req), 0);

    // Reset mid-handshake at medium level.
    level = 2'd2; bx = 11'd5; by = 11'd6; fs = 6'd10;
    dm[5][1] = 1'b1; nm[5][1] = 3'd7;
    step();
    start_frame();
    wait_req("m1", 100, 17);
    check_req("m1", 5, 1, 7, 55, 16);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_req", int'(dif.draw_req), 0);
    check("mrst_x", int'(dif.draw_field_x), 0);
    check("mrst_y", int'(dif.draw_field_y), 0);
    check("mrst_digit", int'(dif.draw_digit), 0);
    check("mrst_xpos", int'(dif.draw_xpos), 0);
    check("mrst_ypos", int'(dif.draw_ypos), 0);
    check("mrst_busy", int'(scan_busy), 0);
    check("mrst_done", int'(scan_done), 0);

    // Level 0 ignores frame_start; a stray ack is ignored too.
    level = 2'd0;
    dif.draw_ack = 1'b1;
    start_frame();
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      seen |= int'(scan_busy) | int'(dif.draw_req) | int'(scan_done);
      step();
    end
    dif.draw_ack = 1'b0;
    check("lvl0_idle", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
